// File: rtl/membrane_ctrl_if.sv
// Button/frame inputs and membrane/round outputs of the osmosis round sequencer.
// master drives buttons and frame strobe; slave is the membrane_ctrl block.
interface membrane_ctrl_if;
    logic       frame;
    logic       btnL;
    logic       btnR;
    logic       btnC;
    logic       btnU;
    logic       magenta_membrane;
    logic       red_membrane;
    logic       blue_membrane;
    logic       no_membrane;
    logic       membrane_on;
    logic       freeze;
    logic       round_over;
    logic [7:0] secs_left;

    modport master (
        output frame, btnL, btnR, btnC, btnU,
        input  magenta_membrane, red_membrane, blue_membrane, no_membrane,
        input  membrane_on, freeze, round_over, secs_left
    );

    modport slave (
        input  frame, btnL, btnR, btnC, btnU,
        output magenta_membrane, red_membrane, blue_membrane, no_membrane,
        output membrane_on, freeze, round_over, secs_left
    );
endinterface

// File: rtl/membrane_ctrl.sv
// Round/membrane sequencer: round FSM, per-round countdown and membrane-switch cooldown.
// Every output is a decode of registered state, so buttons never reach outputs combinationally.
module membrane_ctrl #(
    parameter int ROUND_SECS     = 60,
    parameter int FRAMES_PER_SEC = 60,
    parameter int SWITCH_FRAMES  = 30
) (
    input  logic             clk,
    input  logic             reset,
    membrane_ctrl_if.slave   io
);
    localparam int FC_W = $clog2(FRAMES_PER_SEC);
    localparam int CD_W = (SWITCH_FRAMES < 1) ? 1 : $clog2(SWITCH_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;
    typedef enum logic [1:0] {M_NONE, M_MAGENTA, M_RED, M_BLUE} mode_e;

    localparam int B_L = 0;
    localparam int B_R = 1;
    localparam int B_C = 2;
    localparam int B_U = 3;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [7:0]        secs_q, secs_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CD_W-1:0]   cooldown_q, cooldown_d;
    logic [3:0]        btn_q, btn_d;
    logic [3:0]        btn_edge;
    logic              expire;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no branch can infer a latch.
        state_d     = state_q;
        mode_d      = mode_q;
        secs_d      = secs_q;
        frame_cnt_d = frame_cnt_q;
        cooldown_d  = cooldown_q;
        btn_d       = {io.btnU, io.btnC, io.btnR, io.btnL};
        btn_edge    = btn_d & ~btn_q;
        expire      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (btn_edge[B_C]) state_d = S_RUN;
            end
            S_RUN: begin
                if (io.frame) begin
                    if (frame_cnt_q == FC_W'(FRAMES_PER_SEC - 1)) begin
                        frame_cnt_d = '0;
                        if (secs_q != 8'd0) secs_d = secs_q - 8'd1;
                        expire = (secs_q == 8'd1);
                    end else begin
                        frame_cnt_d = frame_cnt_q + FC_W'(1);
                    end
                end
                // Simultaneous L and R cancel; an accepted change reloads instead of decrementing.
                if ((cooldown_q == '0) && (btn_edge[B_L] ^ btn_edge[B_R])) begin
                    mode_d     = btn_edge[B_R] ? mode_e'(mode_q + 2'd1) : mode_e'(mode_q - 2'd1);
                    cooldown_d = CD_W'(SWITCH_FRAMES);
                end else if (io.frame && (cooldown_q != '0)) begin
                    cooldown_d = cooldown_q - CD_W'(1);
                end
                if (expire)              state_d = S_DONE;
                else if (btn_edge[B_U])  state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (btn_edge[B_U]) state_d = S_RUN;
            end
            S_DONE: begin
                if (btn_edge[B_C]) begin
                    state_d     = S_IDLE;
                    mode_d      = M_NONE;
                    secs_d      = 8'(ROUND_SECS);
                    frame_cnt_d = '0;
                    cooldown_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= M_NONE;
            secs_q      <= 8'(ROUND_SECS);
            frame_cnt_q <= '0;
            cooldown_q  <= '0;
            btn_q       <= btn_d;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            secs_q      <= secs_d;
            frame_cnt_q <= frame_cnt_d;
            cooldown_q  <= cooldown_d;
            btn_q       <= btn_d;
        end
    end

    assign io.magenta_membrane = (mode_q == M_MAGENTA);
    assign io.red_membrane     = (mode_q == M_RED);
    assign io.blue_membrane    = (mode_q == M_BLUE);
    assign io.no_membrane      = (mode_q == M_NONE);
    assign io.membrane_on      = (mode_q != M_NONE);
    assign io.freeze           = (state_q != S_RUN);
    assign io.round_over       = (state_q == S_DONE);
    assign io.secs_left        = secs_q;
endmodule

// File: tb/tb_membrane_ctrl.sv
// Scoreboard bench for membrane_ctrl: directed test-plan sequences then random buttons/frames,
// checked every cycle against a round-level reference model.
module tb_membrane_ctrl;
    localparam int RS = 6;
    localparam int FPS = 4;
    localparam int SW = 3;

    typedef struct packed {
        logic [3:0] sel;
        logic       on;
        logic       frz;
        logic       over;
        logic [7:0] secs;
    } out_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    membrane_ctrl_if bus ();

    membrane_ctrl #(.ROUND_SECS(RS), .FRAMES_PER_SEC(FPS), .SWITCH_FRAMES(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    always #5 clk = ~clk;

    out_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model: round phase, membrane index 0..3 in forward order, frames elapsed in the round.
    int         m_phase = 0;   // 0 idle, 1 run, 2 pause, 3 done
    int         m_mode = 0;
    int         m_elapsed = 0;
    int         m_cd = 0;
    logic [3:0] m_prev = 4'b0;

    task automatic model_step(input logic [3:0] b, input logic fr, input logic rst);
        logic [3:0] e;
        if (rst) begin
            m_phase = 0; m_mode = 0; m_elapsed = 0; m_cd = 0; m_prev = b;
            return;
        end
        e = b & ~m_prev;
        m_prev = b;
        case (m_phase)
            0: if (e[2]) m_phase = 1;
            1: begin
                if (m_cd == 0 && (e[0] != e[1])) begin
                    m_mode = e[1] ? (m_mode + 1) % 4 : (m_mode + 3) % 4;
                    m_cd = SW;
                end else if (fr && m_cd > 0) begin
                    m_cd = m_cd - 1;
                end
                if (fr) m_elapsed = m_elapsed + 1;
                if (m_elapsed == RS * FPS) m_phase = 3;
                else if (e[3]) m_phase = 2;
            end
            2: if (e[3]) m_phase = 1;
            default: if (e[2]) begin
                m_phase = 0; m_mode = 0; m_elapsed = 0; m_cd = 0;
            end
        endcase
    endtask

    function automatic out_t model_out();
        out_t o;
        case (m_mode)
            0: o.sel = 4'b0001;
            1: o.sel = 4'b1000;
            2: o.sel = 4'b0100;
            default: o.sel = 4'b0010;
        endcase
        o.on   = (m_mode != 0);
        o.frz  = (m_phase != 1);
        o.over = (m_phase == 3);
        o.secs = 8'(RS - m_elapsed / FPS);
        return o;
    endfunction

    // b = {U, C, R, L} levels for one cycle.
    task automatic tick(input logic [3:0] b, input logic fr, input logic rst);
        @(negedge clk);
        reset     = rst;
        bus.frame = fr;
        bus.btnL  = b[0];
        bus.btnR  = b[1];
        bus.btnC  = b[2];
        bus.btnU  = b[3];
        model_step(b, fr, rst);
        exp_q.push_back(model_out());
    endtask

    task automatic frames(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) tick(b, 1'b1, 1'b0);
    endtask

    always @(posedge clk) begin
        out_t got, want;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {bus.magenta_membrane, bus.red_membrane, bus.blue_membrane, bus.no_membrane,
                    bus.membrane_on, bus.freeze, bus.round_over, bus.secs_left};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL outputs cyc=%0d got sel=%b on=%b frz=%b over=%b secs=%0d exp sel=%b on=%b frz=%b over=%b secs=%0d",
                         cyc, got.sel, got.on, got.frz, got.over, got.secs,
                         want.sel, want.on, want.frz, want.over, want.secs);
            end
        end
    end

    initial begin
        logic [3:0] lv;
        bus.frame = 1'b0; bus.btnL = 1'b0; bus.btnR = 1'b0; bus.btnC = 1'b1; bus.btnU = 1'b0;

        // btnC held through reset gives no start edge
        tick(4'b0100, 1'b0, 1'b1);
        tick(4'b0100, 1'b0, 1'b1);
        repeat (3) tick(4'b0100, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0100, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);

        // Membrane stepping with cooldown, cancellation and wrap
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        frames(3, 4'b0000);
        tick(4'b0011, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        frames(3, 4'b0000);
        tick(4'b0010, 1'b0, 1'b0);
        frames(3, 4'b0000);
        tick(4'b0001, 1'b0, 1'b0);
        tick(4'b0010, 1'b1, 1'b0);

        // Pause holds timer, cooldown and mode
        tick(4'b1000, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        frames(5, 4'b0000);
        tick(4'b0010, 1'b0, 1'b0);
        frames(5, 4'b0000);
        tick(4'b1000, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);

        // Run out the round, then acknowledge
        frames(16, 4'b0000);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0100, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);

        // Expiry and pause edge together: expiry wins
        tick(4'b0100, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        frames(RS * FPS - 1, 4'b0000);
        tick(4'b1000, 1'b1, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0100, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);

        // Reset mid-round at secs_left=5
        tick(4'b0100, 1'b0, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        frames(FPS, 4'b0000);
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);

        // Random buttons, frames and occasional reset
        lv = 4'b0000;
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(7) == 0) lv[k] = ~lv[k];
            tick(lv, 1'($urandom_range(2) == 0), 1'($urandom_range(299) == 0));
        end

        repeat (4) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/membrane_ctrl.md
Name: membrane_ctrl

Overview:
- Round/membrane sequencer for the osmosis display.
- Generates the membrane-type selects, membrane_on and freeze consumed by every molecule instance and its movement block.
- Owns the round state machine (idle / run / pause / done), the per-round countdown timer and the membrane-switch cooldown.
- Sits between the debounced board buttons and the molecule datapath; all timing is advanced by the per-frame strobe.

Parameters:
- ROUND_SECS, 60: round length in seconds; loaded into secs_left. Legal range 1..255.
- FRAMES_PER_SEC, 60: frame strobes per second of countdown. Must be 2 or more.
- SWITCH_FRAMES, 30: frames of lockout after an accepted membrane change. 0 disables the lockout.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- frame  in  1  one-cycle pulse per video frame.
- btnL  in  1  debounced level; previous membrane type.
- btnR  in  1  debounced level; next membrane type.
- btnC  in  1  debounced level; start round, or acknowledge end of round.
- btnU  in  1  debounced level; pause/resume toggle.
- magenta_membrane  out  1  membrane type is MAGENTA.
- red_membrane  out  1  membrane type is RED.
- blue_membrane  out  1  membrane type is BLUE.
- no_membrane  out  1  membrane type is NONE.
- membrane_on  out  1  high when the type is not NONE.
- freeze  out  1  molecules hold position.
- round_over  out  1  state is DONE.
- secs_left  out  8  remaining seconds, for score/timer display.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, mode=NONE, secs_left=ROUND_SECS, frame_cnt=0, cooldown=0.
  - Button history registers load the current button levels, so a button held through reset produces no edge.
  - Resulting outputs: no_membrane=1, membrane_on=0, freeze=1, round_over=0.
- Edge detect:
  - edge = btn & ~btn_q, with btn_q registered every cycle.
  - Only rising edges act. Held levels never repeat.
- Outputs:
  - All outputs are decodes of registered state; there is no combinational path from inputs to outputs.
  - The four membrane selects are strictly one-hot at all times.
  - freeze = (state != RUN).
- State machine (next state evaluated on the registered state):
  - IDLE:
    - btnC edge -> RUN.
    - All other buttons ignored.
  - RUN:
    - btnU edge -> PAUSE.
    - Timer expiry -> DONE.
    - If btnU edge and expiry occur in the same cycle, DONE wins.
  - PAUSE:
    - btnU edge -> RUN.
    - Timer and cooldown hold.
    - Mode changes are ignored.
  - DONE:
    - btnC edge -> IDLE.
    - On that transition: mode=NONE, secs_left=ROUND_SECS, frame_cnt=0, cooldown=0.
- Timer (acts only when frame=1 and state=RUN):
  - If frame_cnt == FRAMES_PER_SEC-1: frame_cnt=0 and secs_left decrements.
  - Otherwise frame_cnt increments.
  - Expiry is the decrement from 1 to 0. The same edge enters DONE; secs_left reads 0 in DONE.
  - secs_left never wraps below 0.
- Membrane mode (changes only in RUN, and only when cooldown==0):
  - Forward cycle: NONE -> MAGENTA -> RED -> BLUE -> NONE.
  - btnR edge steps forward; btnL edge steps backward; wrap-around in both directions.
  - btnL and btnR edges in the same cycle: both ignored, no cooldown load.
  - An accepted change loads cooldown=SWITCH_FRAMES.
  - cooldown decrements by 1 on each frame while in RUN, saturating at 0.
  - An edge that arrives while cooldown != 0 is dropped, not queued.
  - A mode change and a frame strobe in the same cycle: the change is accepted on the pre-decrement value (cooldown==0 required), then cooldown is loaded with SWITCH_FRAMES; there is no decrement that cycle.
  - Mode persists through PAUSE and DONE, and is cleared only by reset or by DONE -> IDLE.
- Reset mid-round (any state, any counter value): on the next edge the block returns fully to reset values.

Test Plan:
- Reset with btnC held high, then release reset -> stays IDLE with freeze=1. Releasing and re-pressing btnC -> RUN with freeze=0 one cycle after the edge.
- Params ROUND_SECS=2, FRAMES_PER_SEC=4: in RUN, apply 4 frames -> secs_left=1; 4 more frames -> secs_left=0, round_over=1, freeze=1 on the same edge as the 8th frame.
- SWITCH_FRAMES=3, in RUN: btnR edge -> magenta_membrane=1, membrane_on=1. A second btnR edge before 3 frames -> still MAGENTA. After 3 frames, btnR -> RED. btnL from NONE -> BLUE (wrap).
- btnL and btnR rising in the same cycle, in RUN with cooldown=0 -> mode unchanged and a subsequent btnR is accepted immediately.
- btnU in RUN -> PAUSE. 10 frames -> secs_left and cooldown unchanged, and btnR is ignored. btnU -> RUN and counting resumes from the held frame_cnt.
- In DONE with mode=BLUE: btnC -> IDLE, no_membrane=1, secs_left=ROUND_SECS. Separately, assert reset mid-RUN with secs_left=5 -> all outputs return to reset values next cycle.
